// File: rtl/iterative_muldiv.sv
// Multi-cycle RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final stage.
module iterative_muldiv #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned CW   = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            ready,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state;
   logic [CW-1:0]     count;
   logic [2:0]        op_q;
   logic              sa_q;
   logic              sb_q;
   // hi/lo: product accumulator for multiply, remainder/quotient for divide
   logic [XLEN-1:0]   hi_q;
   logic [XLEN-1:0]   lo_q;
   logic [XLEN-1:0]   opnd_q;

   logic              is_div;
   logic              a_sgn;
   logic              b_sgn;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic              spec_hit;
   logic [XLEN-1:0]   spec_res;

   // Operand decode: which operands are signed, and their magnitudes
   always_comb begin
      is_div = op[2];
      a_sgn  = 1'b0;
      b_sgn  = 1'b0;
      case (op)
         OP_MULH, OP_DIV, OP_REM: begin
            a_sgn = a[XLEN-1];
            b_sgn = b[XLEN-1];
         end
         OP_MULHSU: a_sgn = a[XLEN-1];
         default: ;
      endcase
      a_mag = a_sgn ? -a : a;
      b_mag = b_sgn ? -b : b;
   end

   // Cases resolved without iterating: divide by zero, signed overflow, zero product
   always_comb begin
      spec_hit = 1'b0;
      spec_res = '0;
      if (is_div) begin
         if (b == '0) begin
            spec_hit = 1'b1;
            spec_res = op[1] ? a : '1;
         end else if (!op[0] && a == SMIN && b == '1) begin
            spec_hit = 1'b1;
            spec_res = op[1] ? '0 : a;
         end
      end else if (a == '0 || b == '0) begin
         spec_hit = 1'b1;
      end
   end

   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [XLEN-1:0]   hi_nxt;
   logic [XLEN-1:0]   lo_nxt;

   // One iteration step; the remainder invariant (< divisor) keeps the
   // borrow visible in the top bit of an XLEN+1 wide difference
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      if (op_q[2]) begin
         if (!div_diff[XLEN]) begin
            hi_nxt = div_diff[XLEN-1:0];
            lo_nxt = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_nxt = div_shift[XLEN-1:0];
            lo_nxt = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_nxt = mul_sum[XLEN:1];
         lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   fix_res;

   // Sign fix-up and output select
   always_comb begin
      prod = {hi_q, lo_q};
      if (sa_q ^ sb_q)
         prod = -prod;
      case (op_q)
         OP_MUL:                        fix_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               fix_res = (sa_q ^ sb_q) ? -lo_q : lo_q;
         OP_REM, OP_REMU:               fix_res = sa_q ? -hi_q : hi_q;
         default:                       fix_res = '0;
      endcase
   end

   // Control FSM; ready re-asserts one cycle after the result pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ready        <= 1'b1;
         result_valid <= 1'b0;
         result       <= '0;
         count        <= '0;
         op_q         <= '0;
         sa_q         <= 1'b0;
         sb_q         <= 1'b0;
         hi_q         <= '0;
         lo_q         <= '0;
         opnd_q       <= '0;
      end else begin
         result_valid <= 1'b0;
         if (flush) begin
            state <= IDLE;
            ready <= 1'b1;
            count <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (!ready) begin
                     ready <= 1'b1;
                  end else if (start) begin
                     ready <= 1'b0;
                     op_q  <= op;
                     sa_q  <= a_sgn;
                     sb_q  <= b_sgn;
                     hi_q  <= '0;
                     if (spec_hit) begin
                        lo_q  <= spec_res;
                        state <= DONE;
                     end else begin
                        lo_q   <= is_div ? a_mag : b_mag;
                        opnd_q <= is_div ? b_mag : a_mag;
                        count  <= CW'(XLEN - 1);
                        state  <= CALC;
                     end
                  end
               end
               CALC: begin
                  hi_q <= hi_nxt;
                  lo_q <= lo_nxt;
                  if (count == '0)
                     state <= FIX;
                  else
                     count <= count - CW'(1);
               end
               FIX: begin
                  lo_q  <= fix_res;
                  state <= DONE;
               end
               DONE: begin
                  result       <= lo_q;
                  result_valid <= 1'b1;
                  state        <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iterative_muldiv.sv
// Directed self-checking bench for iterative_muldiv at XLEN=32 and XLEN=16.
module tb_iterative_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        ready;
   logic        result_valid;
   logic [31:0] result;

   logic        start16;
   logic [2:0]  op16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic        flush16;
   logic        ready16;
   logic        valid16;
   logic [15:0] result16;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   iterative_muldiv #(.XLEN(32), .CW(6)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .ready(ready), .result_valid(result_valid), .result(result)
   );

   iterative_muldiv #(.XLEN(16), .CW(5)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
      .flush(flush16), .ready(ready16), .result_valid(valid16), .result(result16)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op on the selected instance, then check result, latency and ready timing
   task automatic run_op(input string tag, input bit w16, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      logic v;
      logic [31:0] res;
      logic rdy;
      @(negedge clk);
      if (w16) begin
         op16 = o; a16 = x[15:0]; b16 = y[15:0]; start16 = 1'b1;
      end else begin
         op = o; a = x; b = y; start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0; start16 = 1'b0;
      lat = 0;
      v = 1'b0;
      while (lat < 100 && !v) begin
         @(posedge clk);
         lat++;
         #1 v = w16 ? valid16 : result_valid;
      end
      res = w16 ? {16'h0, result16} : result;
      rdy = w16 ? ready16 : ready;
      check({tag, "_res"}, res, exp);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy"}, {31'h0, rdy}, 32'h0);
      @(posedge clk);
      #1 rdy = w16 ? ready16 : ready;
      v = w16 ? valid16 : result_valid;
      check({tag, "_rdy"}, {31'h0, rdy}, 32'h1);
      check({tag, "_pulse"}, {31'h0, v}, 32'h0);
   endtask

   initial begin
      int  lat;
      bit  seen;
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
      start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; flush16 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'h0, ready}, 32'h1);
      check("rst_valid", {31'h0, result_valid}, 32'h0);
      check("rst_result", result, 32'h0);
      @(negedge clk) rst = 1'b0;

      // Normal iterative ops
      run_op("divu",   1'b0, 3'b101, 32'd100, 32'd7, 32'd14, 34);
      run_op("remu",   1'b0, 3'b111, 32'd100, 32'd7, 32'd2, 34);
      run_op("div_n",  1'b0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      run_op("rem_n",  1'b0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      run_op("mulhsu", 1'b0, 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
      run_op("mulh",   1'b0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      run_op("mulhu",  1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      run_op("mul",    1'b0, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
      run_op("mul_sg", 1'b0, 3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 34);

      // Special cases resolved in one step
      run_op("div0",   1'b0, 3'b100, 32'd55, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("remu0",  1'b0, 3'b111, 32'd12345, 32'd0, 32'd12345, 1);
      run_op("div_ov", 1'b0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ov", 1'b0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
      run_op("mul_z",  1'b0, 3'b000, 32'h0, 32'd5, 32'h0, 1);

      // Start while busy is ignored
      @(negedge clk) op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk) op = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
      check("busy_ready", {31'h0, ready}, 32'h0);
      @(posedge clk);
      #1 start = 1'b0;
      lat = 11;
      while (lat < 100 && !result_valid) begin
         @(posedge clk);
         lat++;
         #1;
      end
      check("ign_res", result, 32'd14);
      check("ign_lat", 32'(lat), 32'd34);
      @(posedge clk);

      // Flush mid-calc: no result, ready next cycle, result held
      @(negedge clk) op = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      check("flush_ready", {31'h0, ready}, 32'h1);
      check("flush_result", result, 32'd14);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1 seen = seen | result_valid;
      end
      check("flush_novalid", {31'h0, seen}, 32'h0);

      // Flush wins over start in the same cycle
      @(negedge clk) op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      check("flush_prio", {31'h0, ready}, 32'h1);

      // Asynchronous reset mid-calc
      @(negedge clk) op = 3'b101; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_ready", {31'h0, ready}, 32'h1);
      check("arst_result", result, 32'h0);
      check("arst_valid", {31'h0, result_valid}, 32'h0);
      @(negedge clk) rst = 1'b0;

      // Narrow instance
      run_op("divu16", 1'b1, 3'b101, 32'd100, 32'd7, 32'd14, 18);
      run_op("remu16", 1'b1, 3'b111, 32'd100, 32'd7, 32'd2, 18);
      run_op("mulh16", 1'b1, 3'b001, 32'h8000, 32'h8000, 32'h4000, 18);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
